// File: rtl/matrix_scan_ctrl.sv
// Row-major scan sequencer: latches a rows x cols size (1..32 each) and issues one
// address/row/col element per valid/ready handshake. Optional MATRIX_SCAN_CTRL_PERF_EN adds cycles_o.
module matrix_scan_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [5:0]        sz_rows_i,
  input  logic [5:0]        sz_cols_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [5:0]        row_o,
  output logic [5:0]        col_o,
  output logic              eol_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_o
`ifdef MATRIX_SCAN_CTRL_PERF_EN
  ,
  output logic [15:0]       cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [5:0]        row_lim, col_lim;
  logic [5:0]        row_q, col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              size_ok, accept, hs, at_eol, at_last;

  assign size_ok = (sz_rows_i != 6'd0) && (sz_rows_i <= 6'd32) &&
                   (sz_cols_i != 6'd0) && (sz_cols_i <= 6'd32);
  assign accept  = (state == IDLE) && start_i && size_ok;
  assign hs      = (state == SCAN) && ready_i;
  // Limits hold size-1, so the end-of-row/matrix tests are plain equality compares.
  assign at_eol  = (col_q == col_lim);
  assign at_last = at_eol && (row_q == row_lim);

  // NOTE: reset is synchronous, so it is tested inside the clocked branch and is absent
  // from the sensitivity list; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SCAN;
      SCAN:    if (hs && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_lim <= '0;
      col_lim <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_i && !size_ok;
      case (state)
        IDLE: if (accept) begin
          row_lim <= sz_rows_i - 6'd1;
          col_lim <= sz_cols_i - 6'd1;
        end
        LOAD: begin
          row_q  <= '0;
          col_q  <= '0;
          addr_q <= '0;
        end
        // The final handshake leaves the counters on the last element.
        SCAN: if (hs && !at_last) begin
          addr_q <= addr_q + ADDR_W'(1);
          if (at_eol) begin
            col_q <= '0;
            row_q <= row_q + 6'd1;
          end else begin
            col_q <= col_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state != IDLE);
  assign valid_o = (state == SCAN);
  assign done_o  = (state == DONE);
  assign err_o   = err_q;
  assign addr_o  = addr_q;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign eol_o   = valid_o && at_eol;
  assign last_o  = valid_o && at_last;

`ifdef MATRIX_SCAN_CTRL_PERF_EN
  logic [15:0] cycles_q;

  always_ff @(posedge clk) begin
    if (!rstn)                                   cycles_q <= '0;
    else if (state == LOAD)                      cycles_q <= '0;
    else if (state == SCAN && cycles_q != 16'hFFFF) cycles_q <= cycles_q + 16'd1;
  end

  assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: a reference model queues expected elements per
// accepted start and a negedge monitor pops one per observed handshake.
module tb_matrix_scan_ctrl;
  localparam int ADDR_W = 10;

  typedef bit bitq_t[$];
  typedef struct {
    int addr;
    int row;
    int col;
    bit eol;
    bit last;
  } elem_t;

  logic              clk       = 1'b0;
  logic              rstn      = 1'b0;
  logic              start_i   = 1'b0;
  logic              ready_i   = 1'b0;
  logic [5:0]        sz_rows_i = '0;
  logic [5:0]        sz_cols_i = '0;
  logic              busy_o, valid_o, eol_o, last_o, done_o, err_o;
  logic [ADDR_W-1:0] addr_o;
  logic [5:0]        row_o, col_o;
`ifdef MATRIX_SCAN_CTRL_PERF_EN
  logic [15:0]       cycles_o;
`endif

  int    checks = 0;
  int    errors = 0;
  elem_t exp_q[$];
  elem_t mon_e;

  matrix_scan_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_i),
    .sz_rows_i (sz_rows_i),
    .sz_cols_i (sz_cols_i),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .addr_o    (addr_o),
    .row_o     (row_o),
    .col_o     (col_o),
    .eol_o     (eol_o),
    .last_o    (last_o),
    .done_o    (done_o),
    .err_o     (err_o)
`ifdef MATRIX_SCAN_CTRL_PERF_EN
    ,
    .cycles_o  (cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the full row-major element list for a rows x cols matrix.
  task automatic push_model(input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        exp_q.push_back('{addr: r * cols + c, row: r, col: c,
                          eol: (c == cols - 1), last: (r == rows - 1 && c == cols - 1)});
  endtask

  // Ready pattern for the SCAN cycles: mode 0 always ready, otherwise ~75% ready.
  function automatic bitq_t make_pat(input int n, input int mode);
    bitq_t p;
    int    ones = 0;
    while (ones < n) begin
      bit b;
      b = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      p.push_back(b);
      ones += int'(b);
    end
    return p;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_elem: got addr %0d, expected no element", addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("elem_addr", 32'(addr_o), mon_e.addr);
        check("elem_row",  32'(row_o),  mon_e.row);
        check("elem_col",  32'(col_o),  mon_e.col);
        check("elem_eol",  32'(eol_o),  32'(mon_e.eol));
        check("elem_last", 32'(last_o), 32'(mon_e.last));
      end
    end
  end

  // One complete scan. Cycle 0 presents start; pat[i] drives ready_i in cycle i+2.
  // The final handshake falls where pat holds its rows*cols-th one (index k), so
  // done_o is expected in cycle k+3 and the scan spends k+1 cycles in SCAN.
  task automatic run_scan(input int rows, input int cols, input bitq_t pat, input bit poke);
    int need = rows * cols;
    int ones = 0;
    int k    = -1;
    foreach (pat[i]) if (k < 0) begin
      ones += int'(pat[i]);
      if (ones == need) k = i;
    end
    next_cycle();
    start_i   = 1'b1;
    sz_rows_i = 6'(rows);
    sz_cols_i = 6'(cols);
    ready_i   = 1'($urandom_range(0, 1));
    push_model(rows, cols);
    @(negedge clk);
    check("start_idle_busy", 32'(busy_o), 0);
    check("start_idle_done", 32'(done_o), 0);
    for (int t = 1; t <= k + 3; t++) begin
      next_cycle();
      start_i   = poke && ($urandom_range(0, 2) == 0);
      sz_rows_i = 6'($urandom_range(0, 40));
      sz_cols_i = 6'($urandom_range(0, 40));
      ready_i   = (t >= 2 && t - 2 < pat.size()) ? pat[t - 2] : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("busy", 32'(busy_o), 1);
      check("done", 32'(done_o), 32'(t == k + 3));
      check("err",  32'(err_o), 0);
    end
    check("queue_drained", exp_q.size(), 0);
`ifdef MATRIX_SCAN_CTRL_PERF_EN
    check("cycles", 32'(cycles_o), k + 1);
`endif
    exp_q.delete();
  endtask

  task automatic bad_start(input int rows, input int cols);
    next_cycle();
    start_i   = 1'b1;
    sz_rows_i = 6'(rows);
    sz_cols_i = 6'(cols);
    ready_i   = 1'b1;
    next_cycle();
    start_i = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err_o),   1);
    check("err_busy",  32'(busy_o),  0);
    check("err_valid", 32'(valid_o), 0);
    next_cycle();
    @(negedge clk);
    check("err_clear", 32'(err_o),  0);
    check("err_idle",  32'(busy_o), 0);
  endtask

  // 4x4 scan aborted by reset while addr 5 is presented (held, since ready is low).
  task automatic reset_mid_scan();
    next_cycle();
    start_i   = 1'b1;
    sz_rows_i = 6'd4;
    sz_cols_i = 6'd4;
    ready_i   = 1'b1;
    push_model(4, 4);
    for (int t = 1; t <= 6; t++) begin
      next_cycle();
      start_i = 1'b0;
      ready_i = 1'b1;
    end
    next_cycle();
    ready_i = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(valid_o), 1);
    check("pre_rst_addr",  32'(addr_o),  5);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_outputs", 32'({busy_o, valid_o, addr_o, row_o, col_o,
                                eol_o, last_o, done_o, err_o}), 0);
    next_cycle();
    @(negedge clk);
    check("abort_no_done", 32'(done_o), 0);
  endtask

  initial begin
    bitq_t p;
    rstn = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs", 32'({busy_o, valid_o, addr_o, row_o, col_o,
                                eol_o, last_o, done_o, err_o}), 0);
`ifdef MATRIX_SCAN_CTRL_PERF_EN
    check("reset_cycles", 32'(cycles_o), 0);
`endif
    next_cycle();
    rstn = 1'b1;

    run_scan(2, 3, make_pat(6, 0), 1'b0);
    p = '{1, 0, 1, 1, 1, 0, 1, 1};
    run_scan(2, 3, p, 1'b0);
    bad_start(0, 5);
    bad_start(4, 33);
    bad_start(40, 0);
    run_scan(1, 1, make_pat(1, 0), 1'b0);
    run_scan(1, 7, make_pat(7, 1), 1'b0);
    run_scan(5, 1, make_pat(5, 1), 1'b0);
    run_scan(32, 32, make_pat(1024, 0), 1'b0);
    reset_mid_scan();
    run_scan(1, 1, make_pat(1, 0), 1'b0);
    run_scan(3, 4, make_pat(12, 1), 1'b1);
    repeat (8) begin
      int r, c;
      r = $urandom_range(1, 32);
      c = $urandom_range(1, 32);
      run_scan(r, c, make_pat(r * c, 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
